// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter for the shared 32x8 program/data memory
//
// Purpose: shares one single-port memory between the CPU core (port 0) and the
// loader/debug port (port 1). Every access is a fixed three-cycle transaction:
// IDLE (arbitrate) -> ACCESS (strobe) -> CAPTURE (read data) -> IDLE (ack).
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   pN_req/we/addr/wdata     per-port request, held stable until the ack cycle
//   pN_ack                   one-cycle registered completion pulse
//   rdata                    read data, valid while the addressed port's ack is high
//   p1_lock                  loader burst lock (only with MEM_ARB_LOCK_EN)
//   cpu_stall                high while port 0 waits for its ack
//   mem_rd/mem_wr            registered memory strobes, high for the ACCESS cycle
//   mem_addr/mem_wdata       registered address/write data of the winning port
//   mem_rdata                memory read data, valid the cycle after mem_rd
//
// Optional feature: define MEM_ARB_LOCK_EN to let port 1 hold the memory for a
// burst while p1_lock is high.
module mem_arbiter #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic          p1_lock,
  output logic          p0_ack,
  output logic          p1_ack,
  output logic [DW-1:0] rdata,
  output logic          cpu_stall,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_e;

  state_e          state_q, state_d;
  logic            last_gnt_q, last_gnt_d;
  logic            gnt_q, gnt_d;       // winner of the transaction in flight
  logic            we_q, we_d;         // in-flight transaction is a write
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            p0_ack_q, p0_ack_d;
  logic            p1_ack_q, p1_ack_d;

  logic            p0_eff, p1_eff;
  logic            grant;
  logic            winner;

  // A request is not counted in the cycle its ack is high; a held request
  // is therefore picked up at the first IDLE after the ack cycle.
  assign p0_eff = p0_req & ~p0_ack_q;
  assign p1_eff = p1_req & ~p1_ack_q;

`ifndef MEM_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = p1_lock;
`endif

  always_comb begin
    grant  = 1'b0;
    winner = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    // During a locked burst the loader's own ack cycle must not hand the slot
    // to port 0: nothing is granted then, and the next IDLE re-grants port 1.
    if (last_gnt_q && p1_lock && p1_req) begin
      grant  = p1_eff;
      winner = 1'b1;
    end else
`endif
    if (p0_eff && p1_eff) begin
      grant  = 1'b1;
      winner = ~last_gnt_q;
    end else if (p0_eff) begin
      grant  = 1'b1;
      winner = 1'b0;
    end else if (p1_eff) begin
      grant  = 1'b1;
      winner = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d     = ACCESS;
          last_gnt_d  = winner;
          gnt_d       = winner;
          we_d        = winner ? p1_we    : p0_we;
          mem_addr_d  = winner ? p1_addr  : p0_addr;
          mem_wdata_d = winner ? p1_wdata : p0_wdata;
          mem_rd_d    = ~we_d;
          mem_wr_d    = we_d;
        end
      end
      ACCESS: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!we_q) begin
          rdata_d = mem_rdata;
        end
        p0_ack_d = ~gnt_q;
        p1_ack_d = gnt_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
    end
  end

  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign rdata     = rdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_stall = p0_req & ~p0_ack_q;

endmodule
